// File: rtl/con2d_stream_driver.sv
// con2d_stream_driver: streams one WIDTH x WIDTH frame into Con2D, appends flush beats,
// and tracks window/pipeline validity until the last convolution result.
module con2d_stream_driver #(
    parameter int DATA_WIDTH = 32,
    parameter int WIDTH      = 7,
    parameter int PIPE_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic [31:0]           counter_col,
    output logic [31:0]           counter_row,
    output logic                  valid_in_pipeline2D,
    output logic [PIPE_DEPTH-1:0] valid_pipeline2D,
    output logic                  conv_valid,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int N    = WIDTH * WIDTH;
    localparam int LAST = N + WIDTH;
    localparam int CW   = $clog2(LAST + 2);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DRAIN} state_t;
    state_t state, state_n;

    logic [CW-1:0] beat_cnt, col_n, row_n, col_q, row_q, idx_q, res_cnt;
    logic accept, issue, done_now;

    assign s_ready     = state == STREAM;
    assign busy        = state != IDLE;
    assign conv_valid  = valid_pipeline2D[PIPE_DEPTH-1];
    assign counter_col = 32'(col_q);
    assign counter_row = 32'(row_q);

    always_comb begin
        state_n  = state;
        accept   = s_ready && s_valid;
        issue    = accept || state == FLUSH;
        done_now = conv_valid && res_cnt == CW'(N - 1);
        case (state)
            IDLE:    state_n = start ? STREAM : IDLE;
            STREAM:  state_n = (accept && beat_cnt == CW'(N - 1)) ? FLUSH : STREAM;
            FLUSH:   state_n = (beat_cnt == CW'(LAST)) ? DRAIN : FLUSH;
            default: state_n = done_now ? IDLE : DRAIN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state               <= IDLE;
            beat_cnt            <= '0;
            col_n               <= '0;
            row_n               <= '0;
            col_q               <= '0;
            row_q               <= '0;
            idx_q               <= '0;
            res_cnt             <= '0;
            o_data              <= '0;
            o_valid             <= 1'b0;
            valid_in_pipeline2D <= 1'b0;
            valid_pipeline2D    <= '0;
            frame_done          <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE) begin
                beat_cnt <= '0;
                col_n    <= '0;
                row_n    <= '0;
            end else if (issue) begin
                // flush beats carry zeros but keep the raster position advancing
                o_data   <= accept ? s_data : '0;
                col_q    <= col_n;
                row_q    <= row_n;
                idx_q    <= beat_cnt;
                beat_cnt <= beat_cnt + CW'(1);
                col_n    <= (col_n == CW'(WIDTH - 1)) ? '0 : col_n + CW'(1);
                row_n    <= (col_n == CW'(WIDTH - 1)) ? row_n + CW'(1) : row_n;
            end
            o_valid             <= issue;
            valid_in_pipeline2D <= o_valid && idx_q >= CW'(WIDTH + 1);
            valid_pipeline2D    <= (valid_pipeline2D << 1) | PIPE_DEPTH'(valid_in_pipeline2D);
            res_cnt             <= done_now ? '0 : conv_valid ? res_cnt + CW'(1) : res_cnt;
            frame_done          <= done_now;
        end
    end
endmodule

// File: tb/tb_con2d_stream_driver.sv
// tb_con2d_stream_driver: directed table and sequence checks of the frame driver.
module tb_con2d_stream_driver;
    localparam int P = 4;
    localparam logic [31:0] B = 32'h3F80_0000;

    logic clk = 1'b0, rst, start, s_valid, s_ready, o_valid, vip, conv_valid, busy, frame_done;
    logic [31:0] s_data, o_data, counter_col, counter_row;
    logic [P-1:0] vp;

    always #5 clk = ~clk;

    con2d_stream_driver #(.DATA_WIDTH(32), .WIDTH(7), .PIPE_DEPTH(P)) dut (
        .clk(clk), .rst(rst), .start(start), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .o_data(o_data), .o_valid(o_valid),
        .counter_col(counter_col), .counter_row(counter_row),
        .valid_in_pipeline2D(vip), .valid_pipeline2D(vp), .conv_valid(conv_valid),
        .busy(busy), .frame_done(frame_done)
    );

    typedef struct {
        int          cyc;
        logic [5:0]  fl;
        int          row;
        int          col;
        logic [31:0] data;
    } vec_t;
    vec_t tab[$];

    int vecs = 0, errs = 0;
    // flags order: {s_ready, o_valid, vip, conv_valid, busy, frame_done}
    logic [5:0]   tr_fl[140];
    logic [15:0]  tr_rc[140];
    logic [31:0]  tr_d[140];
    logic [P-1:0] tr_vp[140];

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int cnt(int b, int lo, int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) n += int'(tr_fl[c][b]);
        return n;
    endfunction

    task automatic run(int nc, int stall_pix, int rst_cyc, int start2, int start3);
        int pix = 0;
        int nst = 0;
        logic acc;
        for (int c = 0; c < nc; c++) begin
            start   = (c == 0) || (c == start2) || (c == start3);
            rst     = (c != rst_cyc);
            s_valid = 1'b1;
            if (stall_pix >= 0 && pix == stall_pix + 1 && nst < 3) begin
                s_valid = 1'b0;
                nst++;
            end
            s_data = B + 32'(pix);
            #1;
            tr_fl[c] = {s_ready, o_valid, vip, conv_valid, busy, frame_done};
            tr_rc[c] = {counter_row[7:0], counter_col[7:0]};
            tr_d[c]  = o_data;
            tr_vp[c] = vp;
            acc = s_valid && s_ready;
            @(posedge clk);
            #1;
            if (acc) pix++;
        end
        start   = 1'b0;
        s_valid = 1'b0;
        rst     = 1'b1;
    endtask

    task automatic check_table(string tag);
        foreach (tab[i]) begin
            chk($sformatf("%s c%0d flags", tag, tab[i].cyc), tr_fl[tab[i].cyc], tab[i].fl);
            chk($sformatf("%s c%0d rowcol", tag, tab[i].cyc), tr_rc[tab[i].cyc],
                64'(tab[i].row * 256 + tab[i].col));
            chk($sformatf("%s c%0d data", tag, tab[i].cyc), tr_d[tab[i].cyc], tab[i].data);
        end
        chk({tag, " vip count"}, cnt(3, 0, 69), 49);
        chk({tag, " conv count"}, cnt(2, 0, 69), 49);
        chk({tag, " beat count"}, cnt(4, 0, 69), 57);
        chk({tag, " done count"}, cnt(0, 0, 69), 1);
    endtask

    initial begin
        logic [4:0] pat;
        tab.push_back('{0,  6'b000000, 0, 0, 32'h0});
        tab.push_back('{1,  6'b100010, 0, 0, 32'h0});
        tab.push_back('{2,  6'b110010, 0, 0, B});
        tab.push_back('{9,  6'b110010, 1, 0, B + 32'd7});
        tab.push_back('{10, 6'b110010, 1, 1, B + 32'd8});
        tab.push_back('{11, 6'b111010, 1, 2, B + 32'd9});
        tab.push_back('{14, 6'b111010, 1, 5, B + 32'd12});
        tab.push_back('{15, 6'b111110, 1, 6, B + 32'd13});
        tab.push_back('{49, 6'b111110, 6, 5, B + 32'd47});
        tab.push_back('{50, 6'b011110, 6, 6, B + 32'd48});
        tab.push_back('{51, 6'b011110, 7, 0, 32'h0});
        tab.push_back('{57, 6'b011110, 7, 6, 32'h0});
        tab.push_back('{58, 6'b011110, 8, 0, 32'h0});
        tab.push_back('{59, 6'b001110, 8, 0, 32'h0});
        tab.push_back('{60, 6'b000110, 8, 0, 32'h0});
        tab.push_back('{63, 6'b000110, 8, 0, 32'h0});
        tab.push_back('{64, 6'b000001, 8, 0, 32'h0});
        tab.push_back('{65, 6'b000000, 8, 0, 32'h0});

        rst = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        run(70, -1, -1, -1, -1);
        check_table("f1");

        // three-cycle upstream stall after pixel 20
        run(72, 20, -1, -1, -1);
        chk("stall c22", {tr_fl[22][4], tr_rc[22], tr_d[22]}, {1'b1, 16'h0206, B + 32'd20});
        for (int c = 23; c <= 25; c++)
            chk($sformatf("stall c%0d", c), {tr_fl[c][4], tr_rc[c], tr_d[c]}, {1'b0, 16'h0206, B + 32'd20});
        chk("stall c26", {tr_fl[26][4], tr_rc[26], tr_d[26]}, {1'b1, 16'h0300, B + 32'd21});
        for (int k = 0; k < 5; k++) pat[4-k] = tr_fl[23+k][3];
        chk("stall vip bubble", pat, 5'b10001);
        for (int i = 0; i < P; i++) begin
            for (int k = 0; k < 5; k++) pat[4-k] = tr_vp[24+i+k][i];
            chk($sformatf("stall vp%0d bubble", i), pat, 5'b10001);
        end
        chk("stall conv count", cnt(2, 0, 71), 49);
        chk("stall done c67", tr_fl[67], 6'b000001);
        chk("stall done count", cnt(0, 0, 71), 1);

        // reset pulse during beat 30 discards the frame
        run(80, -1, 32, -1, -1);
        chk("rst c32", {tr_fl[32][4], tr_rc[32], tr_d[32]}, {1'b1, 16'h0402, B + 32'd30});
        chk("rst c33 flags", tr_fl[33], 6'b0);
        chk("rst c33 rowcol", tr_rc[33], 16'h0);
        chk("rst c33 data", tr_d[33], 32'h0);
        chk("rst c33 vp", tr_vp[33], 4'h0);
        chk("rst busy after", cnt(1, 33, 79), 0);
        chk("rst done count", cnt(0, 0, 79), 0);
        run(70, -1, -1, -1, -1);
        check_table("f3");

        // start ignored mid-stream, honoured in the frame_done cycle
        run(135, -1, -1, 10, 64);
        chk("b2b done c64", tr_fl[64], 6'b000001);
        chk("b2b c65", tr_fl[65], 6'b100010);
        chk("b2b c66", {tr_fl[66], tr_rc[66], tr_d[66]}, {6'b110010, 16'h0, B + 32'd49});
        chk("b2b done c128", tr_fl[128][0], 1'b1);
        chk("b2b done count", cnt(0, 0, 134), 2);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
